// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache: combinational hit path,
// single-line refill from instruction memory on a miss.
module icache_dm #(
    parameter int NUM_BLOCKS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int INDEX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W   = 28 - INDEX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        ALLOC = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];

    logic [INDEX_W-1:0] idx;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               fill;
    logic               unused_inputs;

    assign idx      = proc_addr[2 +: INDEX_W];
    assign req_tag  = proc_addr[29:2+INDEX_W];
    // mem_addr doubles as the latched miss address for the whole refill.
    assign fill_idx = mem_addr[INDEX_W-1:0];
    assign hit      = proc_read & valid_q[idx] & (tag_q[idx] == req_tag);

    assign proc_rdata    = data_q[idx][32*proc_addr[1:0] +: 32];
    assign mem_write     = 1'b0;
    assign mem_wdata     = '0;
    assign unused_inputs = ^{proc_write, proc_wdata};

    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        fill       = 1'b0;
        case (state_q)
            IDLE: begin
                if (proc_read && !hit) begin
                    proc_stall = 1'b1;
                    state_d    = ALLOC;
                end
            end
            ALLOC: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mem_read <= 1'b0;
            mem_addr <= '0;
            valid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == ALLOC) begin
                mem_read <= 1'b1;
                mem_addr <= proc_addr[29:2];
            end
            if (fill) begin
                mem_read          <= 1'b0;
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Line payload and tags need no reset; valid_q alone gates their use.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[fill_idx] <= mem_rdata;
            tag_q[fill_idx]  <= mem_addr[27:INDEX_W];
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: behavioural memory responder plus a
// small valid/tag model predicting hit or miss and stall length per fetch.
module tb_icache_dm;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  bit inject_ready = 0;

  logic [31:0] exp_q[$];
  bit          mv[8];
  logic [24:0] mt[8];

  icache_dm #(.NUM_BLOCKS(8)) dut (
    .clk(clk), .rst(rst),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [27:0] line, input logic [1:0] off);
    logic [31:0] base;
    base = 32'h1111_1111 * ({30'd0, off} + 32'd1);
    return base ^ {line, 4'h0};
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] line);
    return {word_of(line, 2'd3), word_of(line, 2'd2), word_of(line, 2'd1), word_of(line, 2'd0)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory responder: mem_ready pulses mem_lat cycles after mem_read rises
  always begin
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    if (inject_ready) begin
      mem_ready    = 1'b1;
      mem_rdata    = line_of(mem_addr);
      inject_ready = 0;
    end else if (mem_read === 1'b1) begin
      if (wait_cnt == mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = line_of(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mv[i] = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    proc_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch (called at posedge+1) and follow it until the word is delivered.
  task automatic fetch(input logic [29:0] addr);
    logic [2:0]  ix;
    logic [24:0] tg;
    bit          is_hit;
    bit          done;
    int          stalls;
    int          mr_cycles;
    logic [31:0] exp_w;
    ix = addr[4:2];
    tg = addr[29:5];
    is_hit = mv[ix] && (mt[ix] == tg);
    proc_read = 1'b1;
    proc_addr = addr;
    exp_q.push_back(word_of(addr[29:2], addr[1:0]));
    done = 0;
    stalls = 0;
    mr_cycles = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (mem_read) begin
        mr_cycles++;
        chk("mem_addr", mem_addr, addr[29:2]);
      end
      if (!proc_stall) begin
        exp_w = exp_q.pop_front();
        chk("rdata", proc_rdata, exp_w);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      chk("fetch_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    chk("stall_cycles", stalls, is_hit ? 0 : mem_lat + 2);
    chk("mem_read_cycles", mr_cycles, is_hit ? 0 : mem_lat + 1);
    chk("mem_write", mem_write, 0);
    chk("mem_wdata", mem_wdata, 0);
    mv[ix] = 1;
    mt[ix] = tg;
  endtask

  initial begin
    bit seen_ready;
    rst = 1'b1;
    proc_read = 1'b0;
    proc_write = 1'b0;
    proc_addr = '0;
    proc_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", proc_stall, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // first miss with 4-cycle memory, then hits on the rest of the line
    mem_lat = 4;
    fetch(30'h0);
    chk("first_word", proc_rdata, 32'h1111_1111);
    fetch(30'h1);
    fetch(30'h2);
    fetch(30'h3);
    chk("last_word", proc_rdata, 32'h4444_4444);

    // conflict on index 0
    fetch(30'h20);
    fetch(30'h0);

    // address change during ALLOC must not disturb the refill
    apply_reset();
    mem_lat = 3;
    proc_read = 1'b1;
    proc_addr = 30'h0;
    @(negedge clk);
    chk("miss_stall", proc_stall, 1);
    @(posedge clk);
    #1;
    proc_addr = 30'h14;
    seen_ready = 0;
    for (int c = 0; c < 50 && !seen_ready; c++) begin
      @(negedge clk);
      if (mem_read) chk("held_mem_addr", mem_addr, 28'h0);
      seen_ready = mem_ready;
      @(posedge clk);
      #1;
    end
    if (!seen_ready) chk("alloc_timeout", 0, 1);
    mv[0] = 1;
    mt[0] = '0;
    fetch(30'h14);
    fetch(30'h0);

    // reset mid-ALLOC with a coincident mem_ready
    mem_lat = 50;
    proc_read = 1'b1;
    proc_addr = 30'h30;
    seen_ready = 0;
    for (int c = 0; c < 20 && !seen_ready; c++) begin
      @(negedge clk);
      seen_ready = mem_read;
    end
    if (!seen_ready) chk("mem_read_timeout", 0, 1);
    inject_ready = 1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_mem_read", mem_read, 0);
    chk("async_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    proc_read = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    mem_lat = 2;
    fetch(30'h30);

    // zero-wait memory with random fetches and ignored write port
    mem_lat = 0;
    for (int i = 0; i < 16; i++) begin
      proc_write = 1'($urandom_range(0, 1));
      proc_wdata = $urandom;
      fetch(30'($urandom_range(0, 63)));
    end
    proc_write = 1'b0;
    proc_read = 1'b0;
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the pipeline core's instruction-fetch port and the instruction memory. It serves a 32-bit word combinationally on a hit and stalls the core on a miss while it refills a 128-bit line from memory. The core-side ports mirror the core's ICACHE_* bundle one-to-one.

## Interface
- NUM_BLOCKS, 8: number of cache lines; power of two, at least 2. INDEX_W = log2(NUM_BLOCKS).
- One line holds 4 words (128 bits). Word offset is proc_addr[1:0].
- Tag = proc_addr[29:2+INDEX_W]; 25 bits at the default.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- proc_read  in  1  fetch request, from ICACHE_ren.
- proc_write  in  1  from ICACHE_wen; ignored.
- proc_addr  in  30  word address.
- proc_wdata  in  32  ignored.
- proc_stall  out  1  1 while the requested word is not available.
- proc_rdata  out  32  requested word, passed through with no byte reordering.
- mem_read  out  1  line-fill request.
- mem_write  out  1  constant 0.
- mem_addr  out  28  line address.
- mem_wdata  out  128  constant 0.
- mem_rdata  in  128  fill data; [31:0] is word offset 0 and [127:96] is word offset 3.
- mem_ready  in  1  one-cycle pulse marking mem_rdata valid.

## Operation
- Storage per line: valid bit, tag, and 128-bit data. Reset clears every valid bit; data and tags are don't-care.
- FSM states: IDLE and ALLOC.
- IDLE:
  - hit = proc_read & valid[idx] & (tag[idx] == proc_addr tag field).
  - On hit: proc_stall=0 and proc_rdata = selected word, combinationally.
  - If proc_read=0: proc_stall=0 and proc_rdata = the selected line word regardless of valid.
  - On proc_read & !hit: proc_stall=1 in the same cycle. Latch miss_addr = proc_addr[29:2]. Next state ALLOC.
- ALLOC:
  - mem_read=1 and mem_addr=miss_addr (both registered). proc_stall=1.
  - On mem_ready=1: write mem_rdata into line miss_addr[INDEX_W-1:0], set its valid bit, load its tag from miss_addr. Drop mem_read; next state IDLE.
- After the return to IDLE, hit is re-evaluated from the current proc_addr. The core holds the address stable during stall, so this cycle is a hit.
- A change of proc_addr during ALLOC does not affect the fill; the latched miss_addr is used.
- If proc_read falls during ALLOC, the fill still completes.
- mem_ready seen in IDLE is ignored; no state change and no write.
- No replacement policy: a fill overwrites the indexed line unconditionally.
- proc_write and proc_wdata never modify the cache; there is no write path.

## Timing
- Reset values:
  - proc_stall=0 in IDLE with proc_read=0; it is combinational and becomes 1 if proc_read=1 and the access misses.
  - mem_read=0, mem_addr=0, mem_write=0, mem_wdata=0.
  - FSM in IDLE, all lines invalid.
- Hit latency: 0 cycles (combinational). A hit never asserts mem_read.
- Miss timeline:
  - Cycle 0: miss detected, proc_stall=1.
  - Cycle 1: mem_read=1.
  - mem_ready arrives at cycle k ≥ 1; the line is written at the end of cycle k.
  - Cycle k+1: IDLE, mem_read=0, hit, proc_stall=0.
  - Minimum stall is 2 cycles (k=1).
- mem_read stays 1 continuously from cycle 1 through cycle k; mem_addr is stable over the same span.
- Reset asserted mid-ALLOC: mem_read drops to 0 asynchronously, the FSM returns to IDLE, and no line is written or validated even if mem_ready coincides.
- Back-to-back misses to different lines: the second miss is detected in cycle k+1 and stalls again; mem_read returns high at cycle k+2.

## Test plan
- Reset, then proc_read=1, proc_addr=0x0000000, mem_ready 4 cycles after mem_read rises with mem_rdata=0x44444444_33333333_22222222_11111111 -> proc_stall=1 for 6 cycles, mem_addr=0x0000000, then proc_rdata=0x11111111 with proc_stall=0.
- After that fill, proc_addr=0x0000001, 0x0000002, 0x0000003 -> data 0x22222222, 0x33333333, 0x44444444, zero stall, mem_read never asserted.
- Conflict (NUM_BLOCKS=8): fill proc_addr 0x0000000, then read 0x0000020 (same index 0, different tag) -> miss with mem_addr=0x0000008; after the fill, re-reading 0x0000000 misses again.
- Change proc_addr to 0x0000014 during ALLOC of miss 0x0000000 -> mem_addr stays 0x0000000 until mem_ready; then 0x0000014 misses with mem_addr=0x0000005.
- Assert rst while mem_read=1, with mem_ready pulsed in the same cycle -> mem_read=0 immediately; after release, a read of the same address misses again.
- Zero-wait memory (mem_ready high whenever mem_read=1) -> each miss stalls exactly 2 cycles; mem_write=0 and mem_wdata=0 throughout.
